udp_tx_scheduler: RTL and testbench

UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

---
 rtl/udp_tx_scheduler_pkg.sv | 24 ++
 rtl/udp_tx_scheduler_if.sv | 26 ++
 rtl/udp_rr_arb.sv | 32 +++
 rtl/udp_tx_scheduler.sv | 124 ++++++++++++
 tb/tb_udp_tx_scheduler.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_tx_scheduler_pkg.sv
// Shared definitions for the UDP transmit scheduler: state encoding,
// header overheads and payload limits.
package udp_tx_scheduler_pkg;

  localparam int unsigned STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_ARB   = 4'd1;
  localparam state_t ST_START = 4'd2;
  localparam state_t ST_BUSY  = 4'd3;
  localparam state_t ST_GAP   = 4'd4;

  localparam logic [15:0] UDP_HDR   = 16'd8;
  localparam logic [15:0] IPUDP_HDR = 16'd28;

  localparam int unsigned DEF_MIN_PAYLOAD = 18;
  localparam int unsigned DEF_MAX_PAYLOAD = 1472;

  function automatic logic [15:0] pad_len(input logic [15:0] len, input logic [15:0] min_len);
    return (len < min_len) ? min_len : len;
  endfunction

endpackage

// File: rtl/udp_tx_scheduler_if.sv
// Request/length/sender bundle between the scheduler (slave) and its
// clients plus the frame sender (master).
interface udp_tx_scheduler_if;

  logic [1:0]  req;
  logic [15:0] payload_len0;
  logic [15:0] payload_len1;
  logic        tx_done;
  logic [1:0]  grant;
  logic        tx_start;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        err_len;
  logic        err_tmo;

  modport master (
    output req, payload_len0, payload_len1, tx_done,
    input  grant, tx_start, tx_data_length, tx_total_length, err_len, err_tmo
  );

  modport slave (
    input  req, payload_len0, payload_len1, tx_done,
    output grant, tx_start, tx_data_length, tx_total_length, err_len, err_tmo
  );

endinterface

// File: rtl/udp_rr_arb.sv
// Two-way round-robin arbiter; the registered pointer remembers the last
// served channel so the other one wins a tie.
module udp_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served_ch,
  output logic [1:0] winner
);

  logic last_served;

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_served ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

  // Pointer starts at channel 1 so channel 0 takes the first tie after reset.
  always_ff @(posedge clk) begin
    if (!reset_n)
      last_served <= 1'b1;
    else if (update)
      last_served <= served_ch;
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Grants the shared UDP sender to one of two channels, computes the UDP and
// IP lengths, launches the frame and enforces the inter-frame gap.
module udp_tx_scheduler
  import udp_tx_scheduler_pkg::*;
#(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned MIN_PAYLOAD    = DEF_MIN_PAYLOAD,
  parameter int unsigned MAX_PAYLOAD    = DEF_MAX_PAYLOAD,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  udp_tx_scheduler_if.slave bus
);

  localparam int unsigned GAP_LAST = (IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);

  state_t      state;
  logic [1:0]  grant_q;
  logic        tx_start_q;
  logic        err_len_q;
  logic        err_tmo_q;
  logic [15:0] data_len_q;
  logic [15:0] total_len_q;
  logic [15:0] gap_cnt;
  logic [15:0] wdog_cnt;

  logic [1:0]  winner;
  logic        arb_update;
  logic [15:0] sel_len;
  logic [15:0] eff_len;
  logic        len_bad;

  udp_rr_arb u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus.req),
    .update    (arb_update),
    .served_ch (winner[1]),
    .winner    (winner)
  );

  // Rejected requests also move the pointer so a bad channel cannot starve the other.
  always_comb begin
    sel_len    = winner[1] ? bus.payload_len1 : bus.payload_len0;
    len_bad    = sel_len > MAX_LEN;
    eff_len    = pad_len(sel_len, MIN_LEN);
    arb_update = (state == ST_ARB) && (winner != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      grant_q     <= 2'b00;
      tx_start_q  <= 1'b0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      data_len_q  <= 16'd0;
      total_len_q <= 16'd0;
      gap_cnt     <= 16'd0;
      wdog_cnt    <= 16'd0;
    end else begin
      tx_start_q <= 1'b0;
      err_len_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req != 2'b00)
            state <= ST_ARB;
        end
        ST_ARB: begin
          if (winner == 2'b00) begin
            state <= ST_IDLE;
          end else if (len_bad) begin
            err_len_q <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            grant_q     <= winner;
            data_len_q  <= eff_len + UDP_HDR;
            total_len_q <= eff_len + IPUDP_HDR;
            state       <= ST_START;
          end
        end
        ST_START: begin
          tx_start_q <= 1'b1;
          wdog_cnt   <= 16'd0;
          state      <= ST_BUSY;
        end
        // tx_done only matters here; the watchdog forces the gap if it never comes.
        ST_BUSY: begin
          if (bus.tx_done) begin
            grant_q <= 2'b00;
            gap_cnt <= 16'd0;
            state   <= ST_GAP;
          end else if (wdog_cnt == 16'(TMO_LAST)) begin
            err_tmo_q <= 1'b1;
            grant_q   <= 2'b00;
            gap_cnt   <= 16'd0;
            state     <= ST_GAP;
          end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 16'(GAP_LAST))
            state <= ST_IDLE;
          else
            gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant           = grant_q;
  assign bus.tx_start        = tx_start_q;
  assign bus.err_len         = err_len_q;
  assign bus.err_tmo         = err_tmo_q;
  assign bus.tx_data_length  = data_len_q;
  assign bus.tx_total_length = total_len_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: directed frames push expected
// launches/rejections, a negedge monitor pops and compares them.
module tb_udp_tx_scheduler;

  localparam int IFG        = 12;
  localparam int TMO        = 100;
  localparam int KIND_START = 0;
  localparam int KIND_ERR   = 1;

  typedef struct {
    int          kind;
    logic [1:0]  grant;
    logic [15:0] dlen;
    logic [15:0] tlen;
    int          exp_cyc;
    int          min_gap;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_start = -1;
  logic saw_grant0 = 1'b0;

  udp_tx_scheduler_if bus();

  udp_tx_scheduler #(
    .IFG_CYCLES     (IFG),
    .MIN_PAYLOAD    (18),
    .MAX_PAYLOAD    (1472),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [15:0] l0, input logic [15:0] l1);
    @(posedge clk);
    #1;
    bus.req          = r;
    bus.payload_len0 = l0;
    bus.payload_len1 = l1;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    reset_n     = 1'b0;
    bus.req     = 2'b00;
    bus.tx_done = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic pulseDone();
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
  endtask

  task automatic waitGrant(input logic [1:0] g, input string name);
    int n = 0;
    while (bus.grant !== g && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {30'd0, bus.grant}, {30'd0, g});
    tick(1);
  endtask

  task automatic waitStart(input string name);
    int n = 0;
    while (bus.tx_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, bus.tx_start}, 32'd1);
  endtask

  task automatic pushStart(input logic [1:0] g, input logic [15:0] d, input logic [15:0] t,
                           input int ec, input int mg);
    exp_t e;
    e.kind = KIND_START; e.grant = g; e.dlen = d; e.tlen = t; e.exp_cyc = ec; e.min_gap = mg;
    sb.push_back(e);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"},    {30'd0, bus.grant}, 32'd0);
    checkOutput({tag, "_tx_start"}, {31'd0, bus.tx_start}, 32'd0);
    checkOutput({tag, "_err_len"},  {31'd0, bus.err_len}, 32'd0);
    checkOutput({tag, "_err_tmo"},  {31'd0, bus.err_tmo}, 32'd0);
    checkOutput({tag, "_dlen"},     {16'd0, bus.tx_data_length}, 32'd0);
    checkOutput({tag, "_tlen"},     {16'd0, bus.tx_total_length}, 32'd0);
  endtask

  // Every launch or rejection must match the oldest expectation in the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.grant == 2'b01) saw_grant0 = 1'b1;
    if (bus.tx_start === 1'b1 || bus.err_len === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: tx_start=%0b err_len=%0b grant=%0b with nothing expected (cycle %0d)",
                 bus.tx_start, bus.err_len, bus.grant, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("out_kind", bus.err_len ? 32'd1 : 32'd0, e.kind);
        if (e.exp_cyc >= 0) checkOutput("out_cycle", cyc, e.exp_cyc);
        if (e.kind == KIND_START) begin
          checkOutput("start_grant", {30'd0, bus.grant}, {30'd0, e.grant});
          checkOutput("start_dlen",  {16'd0, bus.tx_data_length}, {16'd0, e.dlen});
          checkOutput("start_tlen",  {16'd0, bus.tx_total_length}, {16'd0, e.tlen});
          if (e.min_gap > 0) checkOutput("start_spacing", ((cyc - last_start) >= e.min_gap) ? 32'd1 : 32'd0, 32'd1);
          last_start = cyc;
        end else begin
          checkOutput("err_grant", {30'd0, bus.grant}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    bus.req          = 2'b00;
    bus.payload_len0 = 16'd0;
    bus.payload_len1 = 16'd0;
    bus.tx_done      = 1'b0;
    tick(2);
    checkAllZero("reset");
    reset_n = 1'b1;

    // Single frame on channel 0: 100 bytes -> 108 / 128, three-cycle launch.
    applyStimulus(2'b01, 16'd100, 16'd0);
    pushStart(2'b01, 16'd108, 16'd128, cyc + 3, 0);
    waitGrant(2'b01, "t1_grant");
    bus.req = 2'b00;
    waitStart("t1_start");
    tick(20);
    checkOutput("t1_grant_busy", {30'd0, bus.grant}, 32'd1);
    checkOutput("t1_dlen_busy", {16'd0, bus.tx_data_length}, 32'd108);
    pulseDone();
    checkOutput("t1_grant_gap", {30'd0, bus.grant}, 32'd0);
    checkOutput("t1_tlen_gap", {16'd0, bus.tx_total_length}, 32'd128);
    tick(IFG + 4);

    // Both channels held: grants alternate 01, 10, 01 with full gap spacing.
    applyReset();
    applyStimulus(2'b11, 16'd200, 16'd300);
    pushStart(2'b01, 16'd208, 16'd228, cyc + 3, 0);
    pushStart(2'b10, 16'd308, 16'd328, -1, 50 + IFG + 3);
    pushStart(2'b01, 16'd208, 16'd228, -1, 50 + IFG + 3);
    for (int i = 0; i < 3; i++) begin
      waitStart("t2_start");
      if (i == 2) bus.req = 2'b00;
      tick(50);
      pulseDone();
    end
    tick(IFG + 5);

    // Oversize channel 0 is rejected and channel 1 (5 bytes, padded) goes next.
    applyReset();
    saw_grant0 = 1'b0;
    applyStimulus(2'b11, 16'd1500, 16'd5);
    begin
      exp_t e;
      e.kind = KIND_ERR; e.grant = 2'b00; e.dlen = 16'd0; e.tlen = 16'd0; e.exp_cyc = cyc + 2; e.min_gap = 0;
      sb.push_back(e);
    end
    pushStart(2'b10, 16'd26, 16'd46, cyc + 5, 0);
    waitGrant(2'b10, "t3_grant");
    bus.req = 2'b00;
    waitStart("t3_start");
    tick(10);
    pulseDone();
    tick(IFG + 4);
    checkOutput("t3_never_grant0", {31'd0, saw_grant0}, 32'd0);

    // Missing tx_done: watchdog fires after exactly TMO busy cycles and sticks.
    applyStimulus(2'b01, 16'd100, 16'd5);
    pushStart(2'b01, 16'd108, 16'd128, cyc + 3, 0);
    waitGrant(2'b01, "t4_grant");
    bus.req = 2'b00;
    waitStart("t4_start");
    tick(TMO - 1);
    checkOutput("t4_tmo_early", {31'd0, bus.err_tmo}, 32'd0);
    checkOutput("t4_grant_busy", {30'd0, bus.grant}, 32'd1);
    tick(1);
    checkOutput("t4_tmo_set", {31'd0, bus.err_tmo}, 32'd1);
    checkOutput("t4_grant_gap", {30'd0, bus.grant}, 32'd0);
    tick(IFG + 3);
    applyStimulus(2'b10, 16'd100, 16'd5);
    pushStart(2'b10, 16'd26, 16'd46, cyc + 3, 0);
    waitGrant(2'b10, "t4_grant2");
    bus.req = 2'b00;
    waitStart("t4_start2");
    tick(5);
    pulseDone();
    tick(IFG + 4);
    checkOutput("t4_tmo_sticky", {31'd0, bus.err_tmo}, 32'd1);

    // Reset mid-frame, stale tx_done ignored, fresh request launches normally.
    applyStimulus(2'b01, 16'd100, 16'd5);
    pushStart(2'b01, 16'd108, 16'd128, cyc + 3, 0);
    waitGrant(2'b01, "t5_grant");
    bus.req = 2'b00;
    waitStart("t5_start");
    tick(5);
    reset_n = 1'b0;
    tick(1);
    checkAllZero("t5_reset");
    reset_n = 1'b1;
    tick(2);
    pulseDone();
    tick(20);
    checkOutput("t5_idle_grant", {30'd0, bus.grant}, 32'd0);
    applyStimulus(2'b01, 16'd100, 16'd5);
    pushStart(2'b01, 16'd108, 16'd128, cyc + 3, 0);
    waitGrant(2'b01, "t5_grant2");
    bus.req = 2'b00;
    waitStart("t5_start2");
    tick(10);
    pulseDone();
    tick(IFG + 4);

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
